// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC, single-outstanding imem req/ack handshake and DEPTH-entry prefetch FIFO.
// Define IFQ_BYPASS_EN to present an acked word on ir in the same cycle when the FIFO is empty.
module ifetch_queue #(
  parameter int unsigned   IW       = 16,
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fpc_q, fpc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          discard_q, discard_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] mem_data_q [DEPTH];
  logic [IW-1:0] mem_data_d [DEPTH];
  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [AW-1:0] mem_addr_d [DEPTH];

  logic ack_v;
  logic pending;
  logic head_valid;
  logic bypass;
  logic push;
  logic pop;

  // Handshake qualifiers; pending means the request survives this cycle unacked.
  always_comb begin
    ack_v      = req_q & imem_ack;
    pending    = req_q & ~imem_ack;
    head_valid = (state_q == RUN) && (count_q != '0);
`ifdef IFQ_BYPASS_EN
    bypass     = (state_q == RUN) && (count_q == '0) && ack_v && !discard_q && !redirect && !halt;
`else
    bypass     = 1'b0;
`endif
  end

  always_comb begin
    ir       = '0;
    ir_pc    = '0;
    ir_valid = 1'b0;
    if (bypass) begin
      ir       = imem_rdata;
      ir_pc    = addr_q;
      ir_valid = 1'b1;
    end else if (head_valid) begin
      ir       = mem_data_q[rd_ptr_q];
      ir_pc    = mem_addr_q[rd_ptr_q];
      ir_valid = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    discard_d  = discard_q;
    halted_d   = halted_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_data_d = mem_data_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    pop        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          // Flush; a request still in flight is marked so its word is dropped on ack.
          fpc_d     = redirect_pc;
          discard_d = pending;
          count_d   = '0;
          rd_ptr_d  = '0;
          wr_ptr_d  = '0;
        end else if (halt) begin
          state_d   = pending ? DRAIN : HALTED;
          halted_d  = 1'b1;
          discard_d = 1'b0;
          count_d   = '0;
          rd_ptr_d  = '0;
          wr_ptr_d  = '0;
        end else begin
          if (ack_v) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              fpc_d = fpc_q + AW'(1);
              push  = !(bypass && ir_ready);
            end
          end
          pop = head_valid && ir_ready;
          if (push) begin
            mem_data_d[wr_ptr_q] = imem_rdata;
            mem_addr_d[wr_ptr_q] = addr_q;
            wr_ptr_d             = wr_ptr_q + PW'(1);
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
          count_d = count_q + CW'(push) - CW'(pop);
        end

        // Hold an unacked request; otherwise issue at the next fetch PC if there is room.
        if (pending) begin
          req_d = 1'b1;
        end else begin
          addr_d = fpc_d;
          req_d  = (state_d == RUN) && (count_d < CW'(DEPTH));
        end
      end
      DRAIN: begin
        if (ack_v) begin
          state_d = HALTED;
          req_d   = 1'b0;
          addr_d  = fpc_q;
        end
      end
      HALTED: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = HALTED;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      fpc_q     <= RESET_PC;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      discard_q <= discard_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // FIFO storage needs no reset; count and pointers qualify every read.
  always_ff @(posedge clk) begin
    mem_data_q <= mem_data_d;
    mem_addr_q <= mem_addr_d;
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign halted    = halted_q;

endmodule
